// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RAT pipeline hazard and interrupt sequencer.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN  = 3'd0,
    LDST = 3'd1,
    BRFL = 3'd2,
    IDRN = 3'd3,
    IISS = 3'd4,
    IWT  = 3'd5
  } hz_state_t;

  // RF_WR_SEL encodings; anything other than ALU arrives late from RAM or the IN port
  localparam logic [1:0] RF_SEL_ALU = 2'd0;
  localparam logic [1:0] RF_SEL_SCR = 2'd1;
  localparam logic [1:0] RF_SEL_SP  = 2'd2;
  localparam logic [1:0] RF_SEL_IN  = 2'd3;

  localparam int unsigned BRANCH_FLUSH_CYC_DEF = 2;
  localparam int unsigned LOAD_STALL_CYC_DEF   = 1;
  localparam int unsigned INT_DRAIN_CYC_DEF    = 2;

  function automatic logic rf_sel_is_mem(input logic [1:0] sel);
    return sel != RF_SEL_ALU;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous interrupt request into the clk domain.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use, taken-branch and interrupt-entry sequencer feeding the ID/EX control-vector register.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned BRANCH_FLUSH_CYC = BRANCH_FLUSH_CYC_DEF,
  parameter int unsigned LOAD_STALL_CYC   = LOAD_STALL_CYC_DEF,
  parameter int unsigned INT_DRAIN_CYC    = INT_DRAIN_CYC_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       int_req_i,
  input  logic       i_flag_i,
  input  logic [4:0] id_src_x_i,
  input  logic [4:0] id_src_y_i,
  input  logic       id_use_x_i,
  input  logic       id_use_y_i,
  input  logic       ex_rf_wr_i,
  input  logic       ex_mem_rd_i,
  input  logic [4:0] ex_wb_addr_i,
  input  logic       ex_pc_ld_i,
  output logic       stall_fetch_o,
  output logic       flush_if_o,
  output logic       nop_o,
  output logic       interrupt_o,
  output logic       int_ack_o
);

  // The hazard cycle itself is the first bubble, so the sequence states only cover the rest
  localparam bit         BR_SEQ   = BRANCH_FLUSH_CYC > 1;
  localparam bit         LD_SEQ   = LOAD_STALL_CYC > 1;
  localparam logic [2:0] BR_LOAD  = BR_SEQ ? 3'(BRANCH_FLUSH_CYC - 2) : 3'd0;
  localparam logic [2:0] LD_LOAD  = LD_SEQ ? 3'(LOAD_STALL_CYC - 2) : 3'd0;
  localparam logic [2:0] DRN_LOAD = 3'(INT_DRAIN_CYC - 1);

  hz_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       req_s;
  logic       int_pend;
  logic       load_hz;
  hz_state_t  br_state;

  sync_2ff u_int_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (int_req_i),
    .q_o    (req_s)
  );

  assign int_pend = req_s & i_flag_i;
  assign load_hz  = ex_rf_wr_i & ex_mem_rd_i &
                    ((id_use_x_i & (id_src_x_i == ex_wb_addr_i)) |
                     (id_use_y_i & (id_src_y_i == ex_wb_addr_i)));
  assign br_state = BR_SEQ ? BRFL : RUN;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    stall_fetch_o = 1'b0;
    flush_if_o    = 1'b0;
    nop_o         = 1'b0;
    interrupt_o   = 1'b0;
    int_ack_o     = 1'b0;
    case (state_q)
      RUN: begin
        if (ex_pc_ld_i) begin
          flush_if_o = 1'b1;
          nop_o      = 1'b1;
          state_d    = br_state;
          cnt_d      = BR_LOAD;
        end else if (int_pend) begin
          state_d = IDRN;
          cnt_d   = DRN_LOAD;
        end else if (load_hz) begin
          stall_fetch_o = 1'b1;
          nop_o         = 1'b1;
          state_d       = LD_SEQ ? LDST : RUN;
          cnt_d         = LD_LOAD;
        end
      end
      LDST: begin
        stall_fetch_o = 1'b1;
        nop_o         = 1'b1;
        flush_if_o    = ex_pc_ld_i;
        if (ex_pc_ld_i) begin
          state_d = br_state;
          cnt_d   = BR_LOAD;
        end else if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      BRFL: begin
        flush_if_o = 1'b1;
        nop_o      = 1'b1;
        if (ex_pc_ld_i) begin
          state_d = br_state;
          cnt_d   = BR_LOAD;
        end else if (cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      IDRN: begin
        stall_fetch_o = 1'b1;
        nop_o         = 1'b1;
        flush_if_o    = ex_pc_ld_i;
        if (!i_flag_i) begin
          state_d = ex_pc_ld_i ? br_state : RUN;
          cnt_d   = ex_pc_ld_i ? BR_LOAD : 3'd0;
        end else if (ex_pc_ld_i) begin
          cnt_d = DRN_LOAD;
        end else if (cnt_q == 3'd0) begin
          state_d = IISS;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      IISS: begin
        interrupt_o = 1'b1;
        int_ack_o   = 1'b1;
        flush_if_o  = 1'b1;
        state_d     = IWT;
      end
      IWT: begin
        flush_if_o = 1'b1;
        nop_o      = 1'b1;
        state_d    = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario bench for pipeline_hazard_ctrl: per-cycle expected output vectors go through a scoreboard queue.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  // Output vector order: {stall_fetch, flush_if, nop, interrupt, int_ack}
  localparam logic [4:0] IDLE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b10100;
  localparam logic [4:0] FLUSH = 5'b01100;
  localparam logic [4:0] ENTRY = 5'b01011;

  typedef struct packed {
    logic       useX;
    logic [4:0] srcX;
    logic       useY;
    logic [4:0] srcY;
    logic       rfWr;
    logic [1:0] sel;
    logic       hz;
  } luCase_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       int_req, i_flag;
  logic [4:0] id_src_x, id_src_y, ex_wb_addr;
  logic       id_use_x, id_use_y, ex_rf_wr, ex_mem_rd, ex_pc_ld;
  logic       stall_fetch, flush_if, nop, interrupt, int_ack;
  logic [4:0] obs;
  logic [4:0] expQ [$];
  int         checkCnt = 0;
  int         passCnt  = 0;

  always #5 clk = ~clk;

  assign obs = {stall_fetch, flush_if, nop, interrupt, int_ack};

  pipeline_hazard_ctrl dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .int_req_i     (int_req),
    .i_flag_i      (i_flag),
    .id_src_x_i    (id_src_x),
    .id_src_y_i    (id_src_y),
    .id_use_x_i    (id_use_x),
    .id_use_y_i    (id_use_y),
    .ex_rf_wr_i    (ex_rf_wr),
    .ex_mem_rd_i   (ex_mem_rd),
    .ex_wb_addr_i  (ex_wb_addr),
    .ex_pc_ld_i    (ex_pc_ld),
    .stall_fetch_o (stall_fetch),
    .flush_if_o    (flush_if),
    .nop_o         (nop),
    .interrupt_o   (interrupt),
    .int_ack_o     (int_ack)
  );

  task automatic idle_inputs();
    int_req    = 1'b0;
    i_flag     = 1'b0;
    id_src_x   = 5'd0;
    id_src_y   = 5'd0;
    id_use_x   = 1'b0;
    id_use_y   = 1'b0;
    ex_rf_wr   = 1'b0;
    ex_mem_rd  = 1'b0;
    ex_wb_addr = 5'd0;
    ex_pc_ld   = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] exp;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checkCnt++;
    if (obs !== IDLE) $display("[TB] FAIL reset_hold: got %b want %b", obs, IDLE);
    else passCnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Request raised right after release; cycle 3 is the first drain bubble
    for (int c = 0; c < 4; c++) begin
      int_req = 1'b1;
      i_flag  = 1'b1;
      expQ.push_back((c == 3) ? STALL : IDLE);
      @(negedge clk);
      exp = expQ.pop_front();
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL reset_pre c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    rst_n   = 1'b0;
    int_req = 1'b0;
    #1;
    checkCnt++;
    if (obs !== IDLE) $display("[TB] FAIL reset_mid_idrn: got %b want %b", obs, IDLE);
    else passCnt++;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      expQ.push_back(IDLE);
      @(negedge clk);
      exp = expQ.pop_front();
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL reset_after c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    luCase_t    cases [6];
    logic [4:0] exp;
    cases = '{
      '{1'b1, 5'd5, 1'b0, 5'd0, 1'b1, RF_SEL_SCR, 1'b1},
      '{1'b0, 5'd5, 1'b0, 5'd0, 1'b1, RF_SEL_SCR, 1'b0},
      '{1'b1, 5'd6, 1'b0, 5'd0, 1'b1, RF_SEL_SCR, 1'b0},
      '{1'b0, 5'd0, 1'b1, 5'd5, 1'b1, RF_SEL_IN,  1'b1},
      '{1'b1, 5'd5, 1'b0, 5'd0, 1'b1, RF_SEL_ALU, 1'b0},
      '{1'b1, 5'd5, 1'b0, 5'd0, 1'b0, RF_SEL_SCR, 1'b0}
    };
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 3; c++) begin
        idle_inputs();
        if (c == 0) begin
          id_use_x   = cases[k].useX;
          id_src_x   = cases[k].srcX;
          id_use_y   = cases[k].useY;
          id_src_y   = cases[k].srcY;
          ex_rf_wr   = cases[k].rfWr;
          ex_mem_rd  = rf_sel_is_mem(cases[k].sel);
          ex_wb_addr = 5'd5;
        end
        expQ.push_back((c == 0 && cases[k].hz) ? STALL : IDLE);
        @(negedge clk);
        exp = expQ.pop_front();
        checkCnt++;
        if (obs !== exp) $display("[TB] FAIL load_use k%0d c%0d: got %b want %b", k, c, obs, exp);
        else passCnt++;
        @(posedge clk); #1;
      end
    end
    idle_inputs();
  endtask

  task automatic test_branch();
    logic [4:0] exp;
    for (int c = 0; c < 4; c++) begin
      ex_pc_ld = (c == 0);
      expQ.push_back((c < 2) ? FLUSH : IDLE);
      @(negedge clk);
      exp = expQ.pop_front();
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL branch_single c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    // A second branch in the flush window restarts the two-bubble count from its own cycle
    for (int c = 0; c < 5; c++) begin
      ex_pc_ld = (c < 2);
      expQ.push_back((c < 3) ? FLUSH : IDLE);
      @(negedge clk);
      exp = expQ.pop_front();
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL branch_double c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  task automatic test_interrupt();
    logic [4:0] expTab [8];
    logic [4:0] exp;
    int         pulses = 0;
    expTab = '{IDLE, IDLE, IDLE, STALL, STALL, ENTRY, FLUSH, IDLE};
    for (int c = 0; c < 8; c++) begin
      int_req = (c < 6);
      i_flag  = (c < 6);
      expQ.push_back(expTab[c]);
      @(negedge clk);
      exp = expQ.pop_front();
      if (interrupt === 1'b1) pulses++;
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL interrupt c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    checkCnt++;
    if (pulses !== 1) $display("[TB] FAIL interrupt_pulses: got %0d want 1", pulses);
    else passCnt++;
    idle_inputs();
  endtask

  task automatic test_masked();
    logic [4:0] expTab [6];
    logic [4:0] exp;
    int         pulses = 0;
    expTab = '{IDLE, STALL, STALL, ENTRY, FLUSH, IDLE};
    for (int c = 0; c < 20; c++) begin
      int_req = 1'b1;
      i_flag  = 1'b0;
      expQ.push_back(IDLE);
      @(negedge clk);
      exp = expQ.pop_front();
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL masked c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 6; c++) begin
      int_req = (c < 4);
      i_flag  = (c < 4);
      expQ.push_back(expTab[c]);
      @(negedge clk);
      exp = expQ.pop_front();
      if (interrupt === 1'b1) pulses++;
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL unmask c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    checkCnt++;
    if (pulses !== 1) $display("[TB] FAIL unmask_pulses: got %0d want 1", pulses);
    else passCnt++;
    idle_inputs();
  endtask

  task automatic test_collision();
    logic [4:0] expTab [9];
    logic [4:0] exp;
    int         pulses = 0;
    expTab = '{FLUSH, FLUSH, IDLE, STALL, STALL, ENTRY, FLUSH, IDLE, IDLE};
    for (int c = 0; c < 3; c++) begin
      int_req = 1'b1;
      expQ.push_back(IDLE);
      @(negedge clk);
      exp = expQ.pop_front();
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL collision_pre c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    for (int c = 0; c < 9; c++) begin
      int_req  = (c < 6);
      i_flag   = (c < 6);
      ex_pc_ld = (c == 0);
      expQ.push_back(expTab[c]);
      @(negedge clk);
      exp = expQ.pop_front();
      if (interrupt === 1'b1) pulses++;
      checkCnt++;
      if (obs !== exp) $display("[TB] FAIL collision c%0d: got %b want %b", c, obs, exp);
      else passCnt++;
      @(posedge clk); #1;
    end
    checkCnt++;
    if (pulses !== 1) $display("[TB] FAIL collision_pulses: got %0d want 1", pulses);
    else passCnt++;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d checks", passCnt, checkCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_interrupt();
    test_masked();
    test_collision();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
